// File: rtl/fifo_scoreboard_checker.sv
// rtl/fifo_scoreboard_checker.sv - cycle-accurate shadow-model checker for a synchronous FIFO
// Optional macro FIFO_SCB_ASSERT_EN adds one concurrent assertion per error bit.
module fifo_scoreboard_checker #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  parameter  int FWFT  = 0,
  parameter  int CNT_W = 16,
  localparam int MC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             fifo_write,
  input  logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data_in,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             err_clr,
  output logic [4:0]       err_pulse,
  output logic [4:0]       err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [MC_W-1:0]  model_cnt
);

  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MC_W-1:0] DEPTH_M = MC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pending;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] head_data;
  logic             rd_acc;
  logic             wr_acc;
  logic             data_bad;
  logic [4:0]       err_next;

  assign head_data = mem[head];

  // All checks use the shadow state as it stood before this edge's update.
  always_comb begin
    rd_acc   = fifo_read && (model_cnt != '0);
    wr_acc   = fifo_write && ((model_cnt < DEPTH_M) || rd_acc);
    data_bad = 1'b0;
    if (FWFT != 0) begin
      data_bad = rd_acc && (fifo_data_out != head_data);
    end else begin
      data_bad = pending && (fifo_data_out != exp_data);
    end
    err_next = {fifo_read && !rd_acc,
                fifo_write && !wr_acc,
                data_bad,
                fifo_full != (model_cnt == DEPTH_M),
                fifo_empty != (model_cnt == '0)};
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      head      <= '0;
      tail      <= '0;
      model_cnt <= '0;
      pending   <= 1'b0;
      exp_data  <= '0;
    end else begin
      if (rd_acc) begin
        head <= (head == LAST_P) ? '0 : head + PTR_W'(1);
      end
      if (wr_acc) begin
        tail <= (tail == LAST_P) ? '0 : tail + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   model_cnt <= model_cnt + MC_W'(1);
        2'b01:   model_cnt <= model_cnt - MC_W'(1);
        default: model_cnt <= model_cnt;
      endcase
      // A fresh read re-arms the delayed compare so back-to-back reads are each checked.
      pending <= rd_acc;
      if (rd_acc) begin
        exp_data <= head_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[tail] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_count  <= '0;
    end else begin
      err_pulse <= err_next;
      // A clear wins over the history but the current cycle's errors are still recorded.
      if (err_clr) begin
        err_sticky <= err_next;
        err_count  <= (|err_next) ? CNT_W'(1) : '0;
      end else begin
        err_sticky <= err_sticky | err_next;
        if ((|err_next) && (err_count != '1)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef FIFO_SCB_ASSERT_EN
  a_empty_mismatch: assert property (@(posedge clk) disable iff (!rst_) !err_pulse[0])
    else $display("FAIL:: %0t EMPTY_MISMATCH", $stime);
  a_full_mismatch: assert property (@(posedge clk) disable iff (!rst_) !err_pulse[1])
    else $display("FAIL:: %0t FULL_MISMATCH", $stime);
  a_data_mismatch: assert property (@(posedge clk) disable iff (!rst_) !err_pulse[2])
    else $display("FAIL:: %0t DATA_MISMATCH", $stime);
  a_overflow: assert property (@(posedge clk) disable iff (!rst_) !err_pulse[3])
    else $display("WARNING:: %0t OVERFLOW", $stime);
  a_underflow: assert property (@(posedge clk) disable iff (!rst_) !err_pulse[4])
    else $display("WARNING:: %0t UNDERFLOW", $stime);
`endif

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// tb/tb_fifo_scoreboard_checker.sv - randomized queue-model bench for two checker configurations
module tb_fifo_scoreboard_checker;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic       wr[2], rd[2], clr[2], inj_empty[2], inj_full[2];
  logic [7:0] din[2], inj_xor[2];
  logic       emp_s[2], ful_s[2];
  logic [7:0] dout_s[2];

  logic [4:0]  a_pulse, a_sticky, b_pulse, b_sticky;
  logic [2:0]  a_count;
  logic [15:0] b_count;
  logic [3:0]  a_mcnt;
  logic [2:0]  b_mcnt;

  // Instance 0: DEPTH 8, registered read data, 3-bit counter. Instance 1: DEPTH 5, FWFT.
  function automatic int dep(int i);  return (i == 0) ? 8 : 5;     endfunction
  function automatic bit fw(int i);   return (i == 0) ? 1'b0 : 1'b1; endfunction
  function automatic int cmax(int i); return (i == 0) ? 7 : 65535; endfunction

  fifo_scoreboard_checker #(.DEPTH(8), .WIDTH(8), .FWFT(0), .CNT_W(3)) u_a (
    .clk(clk), .rst_(rst_), .fifo_write(wr[0]), .fifo_read(rd[0]),
    .fifo_data_in(din[0]), .fifo_data_out(dout_s[0]), .fifo_full(ful_s[0]),
    .fifo_empty(emp_s[0]), .err_clr(clr[0]), .err_pulse(a_pulse),
    .err_sticky(a_sticky), .err_count(a_count), .model_cnt(a_mcnt));

  fifo_scoreboard_checker #(.DEPTH(5), .WIDTH(8), .FWFT(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_(rst_), .fifo_write(wr[1]), .fifo_read(rd[1]),
    .fifo_data_in(din[1]), .fifo_data_out(dout_s[1]), .fifo_full(ful_s[1]),
    .fifo_empty(emp_s[1]), .err_clr(clr[1]), .err_pulse(b_pulse),
    .err_sticky(b_sticky), .err_count(b_count), .model_cnt(b_mcnt));

  // Reference: a queue per instance; it also plays an ideal FIFO whose outputs can be corrupted.
  logic [7:0] q[2][$];
  int         mcnt[2]      = '{0, 0};
  logic [7:0] mfront[2]    = '{8'h0, 8'h0};
  logic [7:0] mpexp[2]     = '{8'h0, 8'h0};
  bit         pend[2]      = '{1'b0, 1'b0};
  logic [7:0] pexp[2]      = '{8'h0, 8'h0};
  logic [4:0] exp_pulse[2] = '{5'h0, 5'h0};
  logic [4:0] exp_sticky[2] = '{5'h0, 5'h0};
  int         exp_count[2] = '{0, 0};
  int         n_m;
  bit         rok_m, wok_m;
  logic [4:0] e_m;

  int nchk = 0;
  int nerr = 0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      emp_s[i]  = (mcnt[i] == 0) ^ inj_empty[i];
      ful_s[i]  = (mcnt[i] == dep(i)) ^ inj_full[i];
      dout_s[i] = (fw(i) ? mfront[i] : mpexp[i]) ^ inj_xor[i];
    end
  end

  always @(posedge clk or negedge rst_) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_) begin
        q[i].delete();
        pend[i]       = 1'b0;
        pexp[i]       = 8'h0;
        exp_pulse[i]  = 5'h0;
        exp_sticky[i] = 5'h0;
        exp_count[i]  = 0;
        mcnt[i]   <= 0;
        mfront[i] <= 8'h0;
        mpexp[i]  <= 8'h0;
      end else begin
        n_m   = q[i].size();
        rok_m = rd[i] && (n_m != 0);
        wok_m = wr[i] && ((n_m < dep(i)) || rok_m);
        e_m   = 5'h0;
        e_m[0] = emp_s[i] != (n_m == 0);
        e_m[1] = ful_s[i] != (n_m == dep(i));
        if (fw(i)) e_m[2] = rok_m && (dout_s[i] != q[i][0]);
        else       e_m[2] = pend[i] && (dout_s[i] != pexp[i]);
        e_m[3] = wr[i] && !wok_m;
        e_m[4] = rd[i] && !rok_m;
        pend[i] = rok_m;
        if (rok_m) pexp[i] = q[i].pop_front();
        if (wok_m) q[i].push_back(din[i]);
        exp_pulse[i] = e_m;
        if (clr[i]) begin
          exp_sticky[i] = e_m;
          exp_count[i]  = (e_m != 0) ? 1 : 0;
        end else begin
          exp_sticky[i] = exp_sticky[i] | e_m;
          if ((e_m != 0) && (exp_count[i] < cmax(i))) exp_count[i]++;
        end
        mcnt[i]   <= q[i].size();
        mfront[i] <= (q[i].size() != 0) ? q[i][0] : 8'h0;
        mpexp[i]  <= pexp[i];
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_pulse",  int'(a_pulse),  int'(exp_pulse[0]));
    chk("a_sticky", int'(a_sticky), int'(exp_sticky[0]));
    chk("a_count",  int'(a_count),  exp_count[0]);
    chk("a_mcnt",   int'(a_mcnt),   mcnt[0]);
    chk("b_pulse",  int'(b_pulse),  int'(exp_pulse[1]));
    chk("b_sticky", int'(b_sticky), int'(exp_sticky[1]));
    chk("b_count",  int'(b_count),  exp_count[1]);
    chk("b_mcnt",   int'(b_mcnt),   mcnt[1]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(int i, logic w, logic r, logic [7:0] d);
    wr[i] = w; rd[i] = r; din[i] = d;
    tick();
    wr[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0;
  endtask

  task automatic quiet();
    for (int i = 0; i < 2; i++) begin
      wr[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0; din[i] = 8'h0;
      inj_empty[i] = 1'b0; inj_full[i] = 1'b0; inj_xor[i] = 8'h0;
    end
  endtask

  initial begin
    rst_ = 1'b0;
    quiet();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_pulse", int'(a_pulse), 0);
    chk("rst_a_count", int'(a_count), 0);
    chk("rst_a_mcnt",  int'(a_mcnt),  0);
    chk("rst_b_sticky", int'(b_sticky), 0);
    rst_ = 1'b1;
    repeat (5) tick();
    chk("idle_a_sticky", int'(a_sticky), 0);
    chk("idle_b_sticky", int'(b_sticky), 0);

    for (int k = 0; k < 8; k++) step(0, 1'b1, 1'b0, 8'(8'h10 + k));
    chk("fill8_mcnt", int'(a_mcnt), 8);
    for (int k = 0; k < 8; k++) begin
      inj_xor[0] = (k == 5) ? 8'hEB : 8'h00;
      step(0, 1'b0, 1'b1, 8'h00);
      if (k == 4) chk("clean_reads_count", int'(a_count), 0);
      if (k == 5) chk("corrupt_pulse", int'(a_pulse), 5'b00100);
      if (k == 6) chk("corrupt_one_shot", int'(a_pulse), 0);
    end
    inj_xor[0] = 8'h00;
    step(0, 1'b0, 1'b0, 8'h00);
    chk("drain_mcnt", int'(a_mcnt), 0);
    chk("corrupt_count", int'(a_count), 1);
    clr[0] = 1'b1;
    step(0, 1'b0, 1'b0, 8'h00);
    chk("clr_count", int'(a_count), 0);
    chk("clr_sticky", int'(a_sticky), 0);

    for (int k = 0; k < 8; k++) step(0, 1'b1, 1'b0, 8'(8'h20 + k));
    step(0, 1'b1, 1'b0, 8'hAA);
    chk("ovf_pulse", int'(a_pulse), 5'b01000);
    chk("ovf_mcnt",  int'(a_mcnt),  8);
    step(0, 1'b1, 1'b1, 8'hBB);
    chk("full_rw_pulse", int'(a_pulse), 0);
    chk("full_rw_mcnt",  int'(a_mcnt),  8);
    for (int k = 0; k < 8; k++) step(0, 1'b0, 1'b1, 8'h00);
    step(0, 1'b0, 1'b0, 8'h00);
    chk("full_rw_count", int'(a_count), 1);
    clr[0] = 1'b1;
    step(0, 1'b0, 1'b0, 8'h00);

    step(0, 1'b1, 1'b1, 8'hA5);
    chk("udf_pulse", int'(a_pulse), 5'b10000);
    chk("udf_mcnt",  int'(a_mcnt),  1);
    step(0, 1'b0, 1'b1, 8'h00);
    step(0, 1'b0, 1'b0, 8'h00);
    chk("a5_data_ok", int'(a_pulse), 0);
    chk("a5_mcnt", int'(a_mcnt), 0);
    clr[0] = 1'b1;
    step(0, 1'b0, 1'b0, 8'h00);

    step(0, 1'b1, 1'b0, 8'h33);
    inj_empty[0] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("stuck_empty_pulse", int'(a_pulse), 5'b00001);
      chk("stuck_empty_count", int'(a_count), (n < 7) ? n : 7);
    end
    clr[0] = 1'b1;
    tick();
    chk("clr_wins_count", int'(a_count), 1);
    chk("clr_wins_sticky", int'(a_sticky), 5'b00001);
    inj_empty[0] = 1'b0;
    tick();
    clr[0] = 1'b0;
    chk("clr_clean_count", int'(a_count), 0);
    chk("clr_clean_sticky", int'(a_sticky), 0);
    step(0, 1'b0, 1'b1, 8'h00);
    step(0, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 12; k++) begin
      step(1, 1'b1, (k >= 3), 8'(8'h40 + k));
      if (k == 2) chk("d5_level", int'(b_mcnt), 3);
    end
    for (int k = 0; k < 3; k++) step(1, 1'b0, 1'b1, 8'h00);
    chk("d5_mcnt",  int'(b_mcnt),  0);
    chk("d5_count", int'(b_count), 0);
    chk("d5_sticky", int'(b_sticky), 0);

    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 2; i++) begin
        wr[i]  = (((k / 250) % 2) == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        rd[i]  = (((k / 250) % 2) == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        din[i] = 8'($urandom);
        clr[i] = ($urandom_range(31) == 0);
        inj_xor[i]   = ($urandom_range(15) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
        inj_empty[i] = ($urandom_range(63) == 0);
        inj_full[i]  = ($urandom_range(63) == 0);
      end
      tick();
      if (k == 1000) begin
        rst_ = 1'b0;
        quiet();
        #1;
        chk("midrst_a_mcnt", int'(a_mcnt), 0);
        chk("midrst_b_mcnt", int'(b_mcnt), 0);
        tick();
        tick();
        rst_ = 1'b1;
        repeat (5) tick();
        chk("post_rst_a_sticky", int'(a_sticky), 0);
        chk("post_rst_b_sticky", int'(b_sticky), 0);
      end
    end
    quiet();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard_checker.md
Name: fifo_scoreboard_checker

Overview:
- Parametrised, synthesisable FIFO checker. Successor to the fixed 8x8 property-only FIFO checks.
- Sits beside any synchronous FIFO in the testbench or emulation build. Observes its write/read/flag/data ports and runs a cycle-accurate shadow model of the FIFO.
- Reports flag mismatches, data-ordering errors, overflow and underflow as registered pulses, sticky bits and a saturating error count.
- Adds generic depth/width, a selectable read latency and end-to-end data checking, none of which the earlier checks had.

Parameters:
- DEPTH, 8, FIFO capacity in words. Must be ≥2.
- WIDTH, 8, data width in bits.
- FWFT, 0. 1: DUT data_out is valid in the same cycle as an accepted read. 0: data_out is valid one cycle after the accepted read.
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  sampling clock, rising edge
- rst_  input  1  asynchronous active-low reset
- fifo_write  input  1  DUT write request
- fifo_read  input  1  DUT read request
- fifo_data_in  input  WIDTH  DUT write data
- fifo_data_out  input  WIDTH  DUT read data
- fifo_full  input  1  DUT full flag
- fifo_empty  input  1  DUT empty flag
- err_clr  input  1  synchronous clear of err_sticky and err_count
- err_pulse  output  5  one-cycle error indication, bit map below
- err_sticky  output  5  OR-accumulated err_pulse
- err_count  output  CNT_W  saturating count of cycles with any err_pulse bit set
- model_cnt  output  $clog2(DEPTH+1)  shadow occupancy

Behaviour:
- Reset (rst_ low, asynchronous):
  - model_cnt=0; shadow head/tail pointers=0; pending-compare flag=0.
  - err_pulse=0, err_sticky=0, err_count=0.
  - No checks are evaluated while rst_ is low.
- Error bit map:
  - [0] EMPTY_MISMATCH
  - [1] FULL_MISMATCH
  - [2] DATA_MISMATCH
  - [3] OVERFLOW
  - [4] UNDERFLOW
- Acceptance rules, evaluated each rising edge:
  - rd_acc = fifo_read && model_cnt!=0
  - wr_acc = fifo_write && (model_cnt<DEPTH || rd_acc)
- Shadow model update:
  - wr_acc stores fifo_data_in at the tail.
  - rd_acc pops the head.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
  - model_cnt changes by +1, -1 or 0 accordingly.
- Checks, using pre-update model state at each edge:
  - [0] set when fifo_empty != (model_cnt==0).
  - [1] set when fifo_full != (model_cnt==DEPTH).
  - [3] set when fifo_write && !wr_acc (write into a full FIFO without a read).
  - [4] set when fifo_read && !rd_acc (read from an empty FIFO).
- Simultaneous read+write:
  - On empty: write accepted, read rejected, [4] set. Next cycle model_cnt=1.
  - On full: both accepted, no [3]. model_cnt stays DEPTH.
- Data check:
  - FWFT=1: on rd_acc, compare fifo_data_out with shadow head at the same edge; mismatch sets [2].
  - FWFT=0: on rd_acc, latch shadow head into expected register and set pending. At the next edge with pending=1, compare fifo_data_out; mismatch sets [2]. Pending clears unless a new rd_acc re-arms it, so back-to-back reads are checked every cycle.
- Latency: err_pulse is registered and asserts on the edge after the offending sample. err_sticky and err_count update on the same edge as err_pulse.
- err_count: +1 per cycle with any err_pulse bit set. Saturates at all-ones.
- err_clr:
  - Clears err_sticky and err_count next edge.
  - If err_clr coincides with a new error, the clear wins and the new pulse is then accumulated: result is sticky = that pulse, count = 1.
  - err_clr does not touch the shadow model.
- Reset mid-operation: shadow contents are discarded and pending is dropped. Checking resumes from empty on the first edge after rst_ rises.

Optional Feature:
- Macro FIFO_SCB_ASSERT_EN.
- When defined: adds one concurrent assertion per err_pulse bit, each with disable iff (!rst_). On failure it prints $stime and the check name. OVERFLOW/UNDERFLOW print "WARNING::", all others print "FAIL::".
- When undefined: no assertions or display calls; the block remains fully synthesisable. Outputs are identical in both builds.

Test Plan:
- rst_ low 3 cycles with fifo_empty=1, fifo_full=0 -> all outputs 0. Release, idle 5 cycles -> err_sticky=0.
- DEPTH=8, FWFT=0: write 8 words 0x10..0x17, then read 8 -> model_cnt goes 8 then 0. Correct DUT data gives err_count=0. Corrupt the 5th read to 0xFF -> err_pulse[2] exactly one edge after that read's data cycle; err_count=1.
- Full FIFO, fifo_write=1 with fifo_read=0 -> err_pulse[3]=1, model_cnt stays 8. Same with fifo_read=1 -> no error; head pops, tail written.
- Empty FIFO, fifo_read=1 and fifo_write=1 with data 0xA5 -> err_pulse[4]=1, model_cnt=1. Next read returns 0xA5 with no [2].
- DUT holds fifo_empty=1 after one write -> err_pulse[0] every cycle. err_count increments each cycle until saturation (check with CNT_W=3: holds at 7). err_clr -> count 0, sticky 0.
- DEPTH=5 (non-power-of-2): 12 interleaved writes/reads -> pointer wrap is correct, zero errors. Assert rst_ mid-stream -> model_cnt=0 immediately, no spurious errors after release.
